// File: rtl/sipo_reg_pkg.sv
// Shared constants for the UART receive-path shift register.
package sipo_reg_pkg;

    localparam int SIPO_CHAR_WIDTH = 8;

endpackage : sipo_reg_pkg

// File: rtl/sipo_reg.sv
// Serial-in/parallel-out register for the UART RX path: one bit per enabled
// clock, with a modulo-DATA_WIDTH bit counter and a one-cycle word strobe.
module sipo_reg
    import sipo_reg_pkg::*;
#(
    parameter int DATA_WIDTH = SIPO_CHAR_WIDTH,
    parameter int MSB_FIRST  = 0,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  shift_en,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  word_valid
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  valid_q;
    logic                  valid_d;

    // Next-state for shifter, counter and strobe; disabled cycles hold the partial word.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        valid_d = 1'b0;
        if (shift_en) begin
            if (MSB_FIRST != 0) begin
                shift_d = {shift_q[DATA_WIDTH-2:0], serial_in};
            end else begin
                shift_d = {serial_in, shift_q[DATA_WIDTH-1:1]};
            end
            if (count_q == LAST_BIT) begin
                count_d = {CNT_W{1'b0}};
                valid_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
                valid_d = 1'b0;
            end
        end else begin
            shift_d = shift_q;
            count_d = count_q;
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that overrides shift_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= {DATA_WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign parallel_out = shift_q;
    assign bit_count    = count_q;
    assign word_valid   = valid_q;

endmodule : sipo_reg

// File: tb/tb_sipo_reg.sv
// Directed self-checking bench for sipo_reg in both shift orders.
module tb_sipo_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          reset;
    logic          serial_in;
    logic          shift_en;
    logic [W-1:0]  po_l;
    logic [CW-1:0] bc_l;
    logic          wv_l;
    logic [W-1:0]  po_m;
    logic [CW-1:0] bc_m;
    logic          wv_m;

    int checks = 0;
    int errors = 0;
    int pulses;

    sipo_reg #(.DATA_WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
        .parallel_out(po_l), .bit_count(bc_l), .word_valid(wv_l)
    );

    sipo_reg #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
        .parallel_out(po_m), .bit_count(bc_m), .word_valid(wv_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with given inputs; outputs are settled #1 after the edge.
    task automatic step(input logic rst, input logic en, input logic s);
        @(negedge clk);
        reset     = rst;
        shift_en  = en;
        serial_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_l(input string tag, input int po, input int bc, input int wv);
        check({tag, "_po"}, int'(po_l), po);
        check({tag, "_bc"}, int'(bc_l), bc);
        check({tag, "_wv"}, int'(wv_l), wv);
    endtask

    logic [9:0] seq10;
    logic [7:0] bits;

    initial begin
        reset = 1'b0; shift_en = 1'b0; serial_in = 1'b0;

        // reset overrides an active shift enable
        step(1'b1, 1'b1, 1'b1);
        check_l("reset", 0, 0, 0);
        check("reset_m_po", int'(po_m), 0);

        // LSB-first: 0,1,0,1,1,0,1,0,1,1
        seq10 = 10'b0101101011;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, seq10[9-i]);
            if (i == 7) check("lsb10_wv8", int'(wv_l), 1);
            if (i == 8) check("lsb10_wv9", int'(wv_l), 0);
        end
        check_l("lsb10", 8'hD6, 2, 0);
        check("msb10_po", int'(po_m), 8'h6B);

        // word strobe: 1,0,0,0,0,0,0,1 then 1,1,0,0,1,0,1,0
        step(1'b1, 1'b0, 1'b0);
        bits = 8'b10000001;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, bits[7-i]);
            if (i < 7) check("ws_early_wv", int'(wv_l), 0);
        end
        check_l("ws_word1", 8'h81, 0, 1);
        bits = 8'b11001010;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, bits[7-i]);
            if (wv_l) pulses++;
            if (i == 0) check("ws_no_double", int'(wv_l), 0);
        end
        check_l("ws_word2", 8'h53, 0, 1);
        check("ws_pulses2", pulses, 1);

        // enable gating: 3 bits then 5 idle cycles with serial_in toggling
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_l("gate_pre", 8'hA0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'(i % 2));
            check_l("gate_hold", 8'hA0, 3, 0);
        end

        // mid-word reset then one full word
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        check("mid_bc5", int'(bc_l), 5);
        step(1'b1, 1'b1, 1'b1);
        check_l("mid_reset", 0, 0, 0);
        pulses = 0;
        bits = 8'b01101100;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, bits[7-i]);
            if (wv_l) pulses++;
        end
        check_l("mid_word", 8'h36, 0, 1);
        step(1'b0, 1'b0, 1'b0);
        if (wv_l) pulses++;
        check("mid_pulses", pulses, 1);

        // MSB-first: 1,0,1,0,0,1,0,1
        step(1'b1, 1'b0, 1'b0);
        bits = 8'b10100101;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, bits[7-i]);
        check("msb_po", int'(po_m), 8'hA5);
        check("msb_bc", int'(bc_m), 0);
        check("msb_wv", int'(wv_m), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sipo_reg
